// File: rtl/sram_arbiter.sv
// Shares one SRAM read/write port between instruction fetch and load/store.
// Data has priority; a starvation counter forces a fetch grant after STARVE_LIMIT denied cycles.
module sram_arbiter #(
    parameter int ADDR_WIDTH   = 28,
    parameter int DATA_WIDTH   = 32,
    parameter int NUM_WMASKS   = 4,
    parameter int READ_LATENCY = 1,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_ni,
    input  logic                  ireq_valid_i,
    output logic                  ireq_ready_o,
    input  logic [ADDR_WIDTH-1:0] ireq_addr_i,
    output logic                  irsp_valid_o,
    output logic [DATA_WIDTH-1:0] irsp_rdata_o,
    input  logic                  dreq_valid_i,
    output logic                  dreq_ready_o,
    input  logic                  dreq_we_i,
    input  logic [ADDR_WIDTH-1:0] dreq_addr_i,
    input  logic [DATA_WIDTH-1:0] dreq_wdata_i,
    input  logic [NUM_WMASKS-1:0] dreq_wmask_i,
    output logic                  drsp_valid_o,
    output logic [DATA_WIDTH-1:0] drsp_rdata_o,
    output logic                  sram_csb_o,
    output logic                  sram_web_o,
    output logic [ADDR_WIDTH-1:0] sram_addr_o,
    output logic [DATA_WIDTH-1:0] sram_wdata_o,
    output logic [NUM_WMASKS-1:0] sram_wmask_o,
    input  logic [DATA_WIDTH-1:0] sram_rdata_i
);
    localparam int CW = $clog2(STARVE_LIMIT + 1);
    localparam logic [CW-1:0] LIMIT = CW'(STARVE_LIMIT);

    logic [CW-1:0]           starve_cnt_q, starve_cnt_d;
    logic [READ_LATENCY-1:0] vld_q, vld_d;
    // id bit per tracker stage: 1 = fetch, 0 = data
    logic [READ_LATENCY-1:0] id_q, id_d;
    logic                    force_fetch, gnt_d_raw, gnt_i_raw, gnt_d, gnt_i;

    always_comb begin
        force_fetch  = ireq_valid_i && (starve_cnt_q == LIMIT);
        gnt_d_raw    = dreq_valid_i && !force_fetch;
        gnt_i_raw    = ireq_valid_i && !gnt_d_raw;
        // State updates use the raw grants; reset already holds the flops.
        // Only the externally visible grant is gated by reset.
        gnt_d        = gnt_d_raw && rst_ni;
        gnt_i        = gnt_i_raw && rst_ni;

        starve_cnt_d = starve_cnt_q;
        if (!ireq_valid_i || gnt_i_raw) begin
            starve_cnt_d = '0;
        end else if (starve_cnt_q < LIMIT) begin
            starve_cnt_d = starve_cnt_q + 1'b1;
        end

        vld_d    = '0;
        id_d     = '0;
        vld_d[0] = (gnt_d_raw && !dreq_we_i) || gnt_i_raw;
        id_d[0]  = gnt_i_raw;
        for (int i = 1; i < READ_LATENCY; i++) begin
            vld_d[i] = vld_q[i-1];
            id_d[i]  = id_q[i-1];
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_cnt_q <= '0;
            vld_q        <= '0;
            id_q         <= '0;
        end else begin
            starve_cnt_q <= starve_cnt_d;
            vld_q        <= vld_d;
            id_q         <= id_d;
        end
    end

    always_comb begin
        sram_csb_o   = 1'b1;
        sram_web_o   = 1'b1;
        sram_addr_o  = '0;
        sram_wdata_o = '0;
        sram_wmask_o = '0;
        if (gnt_d) begin
            sram_csb_o   = 1'b0;
            sram_web_o   = ~dreq_we_i;
            sram_addr_o  = dreq_addr_i;
            sram_wdata_o = dreq_wdata_i;
            sram_wmask_o = dreq_wmask_i;
        end else if (gnt_i) begin
            sram_csb_o  = 1'b0;
            sram_addr_o = ireq_addr_i;
        end
    end

    assign ireq_ready_o = gnt_i;
    assign dreq_ready_o = gnt_d;
    assign irsp_valid_o = vld_q[READ_LATENCY-1] && id_q[READ_LATENCY-1];
    assign drsp_valid_o = vld_q[READ_LATENCY-1] && !id_q[READ_LATENCY-1];
    assign irsp_rdata_o = sram_rdata_i;
    assign drsp_rdata_o = sram_rdata_i;

endmodule

// File: tb/tb_sram_arbiter.sv
// Drives two arbiters (read latency 1 and 3) with identical stimulus and checks both
// against a cycle-level reference model of grants, SRAM drive and response timing.
module tb_sram_arbiter;
    localparam int LIMIT = 4;

    logic clk = 1'b0;
    logic rst_n;
    logic iv, dv, we;
    logic [27:0] ia, da;
    logic [31:0] wd;
    logic [3:0]  wm;

    logic        irdy [2], drdy [2], irv [2], drv [2], csb [2], web [2];
    logic [27:0] saddr [2];
    logic [31:0] swd [2], srd [2], ird [2], drd [2];
    logic [3:0]  swm [2];

    always #5 clk = ~clk;

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int L = (g == 0) ? 1 : 3;
        logic [31:0] mem [32];
        logic [31:0] rpipe [L];

        initial for (int i = 0; i < 32; i++) mem[i] = '0;

        // Behavioural SRAM: masked write at the edge, read data delayed L cycles
        always @(posedge clk) begin
            if (!csb[g]) begin
                if (!web[g]) begin
                    for (int b = 0; b < 4; b++)
                        if (swm[g][b]) mem[saddr[g][4:0]][b*8 +: 8] <= swd[g][b*8 +: 8];
                end else begin
                    rpipe[0] <= mem[saddr[g][4:0]];
                end
            end
            for (int i = 1; i < L; i++) rpipe[i] <= rpipe[i-1];
        end
        assign srd[g] = rpipe[L-1];

        sram_arbiter #(.READ_LATENCY(L), .STARVE_LIMIT(LIMIT)) u_dut (
            .clk_i(clk), .rst_ni(rst_n),
            .ireq_valid_i(iv), .ireq_ready_o(irdy[g]), .ireq_addr_i(ia),
            .irsp_valid_o(irv[g]), .irsp_rdata_o(ird[g]),
            .dreq_valid_i(dv), .dreq_ready_o(drdy[g]), .dreq_we_i(we),
            .dreq_addr_i(da), .dreq_wdata_i(wd), .dreq_wmask_i(wm),
            .drsp_valid_o(drv[g]), .drsp_rdata_o(drd[g]),
            .sram_csb_o(csb[g]), .sram_web_o(web[g]), .sram_addr_o(saddr[g]),
            .sram_wdata_o(swd[g]), .sram_wmask_o(swm[g]), .sram_rdata_i(srd[g])
        );
    end

    int n_chk = 0, n_err = 0, cyc = 0;

    task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @cyc %0d: got %0h expected %0h", tag, cyc, got, exp);
        end
    endtask

    // Reference model: accepted reads with the data they must return
    typedef struct {int cyc; bit fetch; logic [31:0] data;} acc_t;
    acc_t        acc[$];
    logic [31:0] shadow [32];
    int          m_cnt = 0;
    bit          last_gi, last_gd;
    int          fetch_seen;

    task automatic step();
        bit ff, egd, egi, found, fport;
        logic [31:0] fdata;
        int L;
        @(negedge clk);
        if (!rst_n) begin
            acc.delete();
            m_cnt = 0;
        end
        ff  = iv && (m_cnt == LIMIT);
        egd = rst_n && dv && !ff;
        egi = rst_n && iv && !egd;
        for (int g = 0; g < 2; g++) begin
            chk("ireq_ready", irdy[g], egi);
            chk("dreq_ready", drdy[g], egd);
            chk("sram_csb", csb[g], !(egd || egi));
            chk("sram_web", web[g], egd ? !we : 1'b1);
            chk("sram_addr", saddr[g], egd ? da : (egi ? ia : 28'h0));
            chk("sram_wdata", swd[g], egd ? wd : 32'h0);
            chk("sram_wmask", swm[g], egd ? wm : 4'h0);
            L = (g == 0) ? 1 : 3;
            found = 0; fport = 0; fdata = '0;
            foreach (acc[i]) if (acc[i].cyc == cyc - L) begin
                found = 1; fport = acc[i].fetch; fdata = acc[i].data;
            end
            chk("irsp_valid", irv[g], found && fport);
            chk("drsp_valid", drv[g], found && !fport);
            if (found && fport)  chk("irsp_rdata", ird[g], fdata);
            if (found && !fport) chk("drsp_rdata", drd[g], fdata);
        end
        if (irdy[0]) fetch_seen++;
        if (egd && !we) acc.push_back('{cyc, 1'b0, shadow[da[4:0]]});
        if (egi)        acc.push_back('{cyc, 1'b1, shadow[ia[4:0]]});
        if (egd && we)
            for (int b = 0; b < 4; b++) if (wm[b]) shadow[da[4:0]][b*8 +: 8] = wd[b*8 +: 8];
        if (!rst_n || !iv || egi) m_cnt = 0;
        else if (m_cnt < LIMIT) m_cnt++;
        while (acc.size() > 0 && acc[0].cyc < cyc - 3) void'(acc.pop_front());
        last_gi = egi;
        last_gd = egd;
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic idle(input int n);
        iv = 0; dv = 0;
        repeat (n) step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) shadow[i] = '0;
        rst_n = 0; iv = 1; dv = 1; we = 0; ia = 28'h3; da = 28'h4; wd = '0; wm = '0;
        // Reset held with both requesters asking: nothing may be granted
        repeat (3) step();
        rst_n = 1;
        step();                                   // data must win the first cycle
        idle(4);

        // Data write then fetch read of the same word
        dv = 1; we = 1; da = 28'h10; wd = 32'hDEADBEEF; wm = 4'hF; step();
        dv = 0; iv = 1; ia = 28'h10; step();
        idle(4);

        // Byte mask: bytes 0 and 2 cleared
        dv = 1; we = 1; da = 28'h5; wd = 32'hFFFFFFFF; wm = 4'hF; step();
        wd = 32'h0; wm = 4'b0101; step();
        we = 0; step();
        idle(4);

        // Starvation: fetch forced every LIMIT+1 cycles
        fetch_seen = 0;
        iv = 1; ia = 28'h7; dv = 1; we = 0; da = 28'h5;
        repeat (20) step();
        chk("starve_fetch_grants", fetch_seen, 20 / (LIMIT + 1));
        idle(4);

        // Alternating single-requester reads every cycle
        for (int k = 0; k < 10; k++) begin
            iv = (k % 2 == 0); dv = (k % 2 == 1); we = 0;
            ia = 28'(k); da = 28'(k + 16);
            step();
        end
        idle(4);

        // Reset one cycle after a read accept: response must be dropped
        dv = 1; we = 0; da = 28'h10; step();
        dv = 0; rst_n = 0; step(); step();
        rst_n = 1;
        idle(5);

        // Randomized traffic; requests held stable until accepted
        iv = 0; dv = 0;
        for (int k = 0; k < 400; k++) begin
            if (!iv || last_gi) begin
                iv = ($urandom_range(0, 2) != 0);
                ia = 28'($urandom_range(0, 31));
            end
            if (!dv || last_gd) begin
                dv = ($urandom_range(0, 2) != 0);
                we = $urandom_range(0, 1);
                da = 28'($urandom_range(0, 31));
                wd = $urandom;
                wm = 4'($urandom_range(0, 15));
            end
            rst_n = ($urandom_range(0, 99) != 0);
            last_gi = 0; last_gd = 0;
            step();
            rst_n = 1;
        end
        idle(5);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule

// File: doc/sram_arbiter.md
# sram_arbiter

Two-port arbiter that shares the single read/write port of the on-chip SRAM macro wrapper between the core's instruction-fetch requester and its load/store requester. Each requester uses a valid/ready request handshake and receives a fixed-latency read response. Data accesses have priority; a starvation counter guarantees fetch progress. The block sits between the core's memory interfaces and the SRAM wrapper.

## Interface
- ADDR_WIDTH, 28: word address width on requester and SRAM sides
- DATA_WIDTH, 32: data width
- NUM_WMASKS, 4: byte write-mask width (DATA_WIDTH/8)
- READ_LATENCY, 1: cycles from SRAM accept to valid `sram_rdata_i`; legal range 1..4
- STARVE_LIMIT, 4: consecutive denied fetch cycles before fetch is forced; legal range ≥1

Ports:
- clk_i  in  1  clock, all logic on rising edge
- rst_ni  in  1  asynchronous active-low reset
- ireq_valid_i  in  1  fetch request valid
- ireq_ready_o  out  1  fetch request accepted this cycle
- ireq_addr_i  in  ADDR_WIDTH  fetch address
- irsp_valid_o  out  1  fetch read data valid (one-cycle pulse)
- irsp_rdata_o  out  DATA_WIDTH  fetch read data
- dreq_valid_i  in  1  data request valid
- dreq_ready_o  out  1  data request accepted this cycle
- dreq_we_i  in  1  1 = write, 0 = read
- dreq_addr_i  in  ADDR_WIDTH  data address
- dreq_wdata_i  in  DATA_WIDTH  write data
- dreq_wmask_i  in  NUM_WMASKS  byte enables for writes
- drsp_valid_o  out  1  data read valid (reads only)
- drsp_rdata_o  out  DATA_WIDTH  data read data
- sram_csb_o  out  1  SRAM chip select, active low
- sram_web_o  out  1  SRAM write enable, active low (1 = read)
- sram_addr_o  out  ADDR_WIDTH  SRAM address
- sram_wdata_o  out  DATA_WIDTH  SRAM write data
- sram_wmask_o  out  NUM_WMASKS  SRAM byte mask
- sram_rdata_i  in  DATA_WIDTH  SRAM read data

## Operation
- Grant is combinational per cycle; at most one request is granted. `*_ready_o` is high only for the granted requester; a request transfers on valid && ready at the rising edge.
- Priority: data wins unless `starve_cnt == STARVE_LIMIT` and fetch is valid, in which case fetch wins.
- starve_cnt (width clog2(STARVE_LIMIT+1)):
  - Increments when fetch is valid and not granted; saturates at STARVE_LIMIT.
  - Clears when fetch is granted or `ireq_valid_i` is low.
- SRAM drive on grant:
  - `sram_csb_o = 0`
  - addr from the winner
  - `sram_web_o = ~dreq_we_i` for data, `1` for fetch
  - wdata/wmask from data port, zero for fetch
- SRAM drive with no grant: `csb = 1`, `web = 1`, addr/wdata/wmask = 0.
- Response tracking: READ_LATENCY-deep shift register of {valid, id}.
  - Stage 0 loads valid = (grant && read), id = fetch/data.
  - On exiting the last stage, assert `irsp_valid_o` or `drsp_valid_o` for the tagged id.
  - Both rdata outputs are driven from `sram_rdata_i` combinationally.
- Writes produce no response.
- Responses have no backpressure; requesters must accept them.
- Requesters hold valid, addr, wdata, wmask and we stable until ready. The arbiter does not check this.

## Timing
- Reset (async assert, sync release): starve_cnt = 0, all tracker valids = 0, `irsp_valid_o = drsp_valid_o = 0`.
- Outputs during reset: `sram_csb_o = 1`, `sram_web_o = 1`, both ready = 0 (grant gated by reset).
- Read accepted at edge N → `*rsp_valid_o` high during cycle N+READ_LATENCY for exactly one cycle, with matching rdata.
- Throughput: one access per cycle; back-to-back grants are allowed, including mixed fetch/data and read-after-write to the same address.
- Fairness: under continuous demand from both ports, fetch is granted every STARVE_LIMIT+1 cycles.
- Reset asserted mid-operation: in-flight responses are discarded and no response pulse appears after release.
- Both valids low: no SRAM access; starve_cnt clears.

## Test plan
- Reset check: hold rst_ni = 0 with both valids high → csb = 1, web = 1, both ready = 0, no rsp valids. Release → data granted the first cycle.
- Fetch-only read, READ_LATENCY = 1: write 0xDEADBEEF at addr 0x10 via data port, then fetch addr 0x10 → `irsp_valid_o` one cycle after accept with 0xDEADBEEF; `drsp_valid_o` stays 0.
- Byte mask: write 0xFFFFFFFF, then write 0x00000000 with mask 4'b0101, then read → `drsp_rdata_o` = 0xFF00FF00.
- Starvation, STARVE_LIMIT = 4: both valids held high for 20 cycles → fetch granted on cycles 4, 9, 14, 19; data granted on the other 16.
- Latency sweep READ_LATENCY = 3: alternating fetch/data reads every cycle → each response arrives exactly 3 cycles after its accept, on the correct port, in order.
- Reset mid-flight: assert rst_ni low one cycle after a read accept (READ_LATENCY = 2) → no rsp valid pulse after release.
